// File: rtl/axi4_lite_slave_responder.sv
// AXI4-Lite slave responder: zero-initialised register memory behind independent write and read
// paths, with per-channel wait states and an address window that selects OKAY or DECERR.
module axi4_lite_slave_responder #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              MEM_DEPTH     = 16,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = ADDRESS_WIDTH'(32'h0000_0000),
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = ADDRESS_WIDTH'(32'h0000_003F),
  parameter int unsigned              WAIT_AW       = 0,
  parameter int unsigned              WAIT_W        = 0,
  parameter int unsigned              WAIT_B        = 0,
  parameter int unsigned              WAIT_AR       = 0,
  parameter int unsigned              WAIT_R        = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W    = 4;

  localparam logic [ADDRESS_WIDTH-1:0] SPAN = MAX_ADDRESS - MIN_ADDRESS;

  localparam logic [CNT_W-1:0] WAIT_AW_C = CNT_W'(WAIT_AW);
  localparam logic [CNT_W-1:0] WAIT_W_C  = CNT_W'(WAIT_W);
  localparam logic [CNT_W-1:0] WAIT_B_C  = CNT_W'(WAIT_B);
  localparam logic [CNT_W-1:0] WAIT_AR_C = CNT_W'(WAIT_AR);
  localparam logic [CNT_W-1:0] WAIT_R_C  = CNT_W'(WAIT_R);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    CAP_IDLE,
    CAP_DONE
  } cap_state_t;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_VALID
  } rsp_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  cap_state_t                aw_state, aw_state_nx;
  logic [CNT_W-1:0]          aw_cnt, aw_cnt_nx;
  logic [ADDRESS_WIDTH-1:0]  aw_addr_q, aw_addr_nx;

  cap_state_t                w_state, w_state_nx;
  logic [CNT_W-1:0]          w_cnt, w_cnt_nx;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_nx;
  logic [STRB_W-1:0]         w_strb_q, w_strb_nx;

  rsp_state_t                b_state, b_state_nx;
  logic [CNT_W-1:0]          b_cnt, b_cnt_nx;
  logic [1:0]                bresp_q, bresp_nx;

  cap_state_t                ar_state, ar_state_nx;
  logic [CNT_W-1:0]          ar_cnt, ar_cnt_nx;

  rsp_state_t                r_state, r_state_nx;
  logic [CNT_W-1:0]          r_cnt, r_cnt_nx;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_nx;
  logic [1:0]                rresp_q, rresp_nx;

  logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                      commit, wr_en, wr_hit, rd_hit;
  logic [ADDRESS_WIDTH-1:0]  wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic [IDX_W-1:0]          wr_idx, rd_idx;
  logic                      unused_prot;

  assign unused_prot = ^{awprot, arprot};

  // Ready is a pure decode of channel state, forced low while reset is held.
  assign awready = (aw_state == CAP_IDLE) && (aw_cnt == WAIT_AW_C) && !areset;
  assign wready  = (w_state  == CAP_IDLE) && (w_cnt  == WAIT_W_C)  && !areset;
  assign arready = (ar_state == CAP_IDLE) && (ar_cnt == WAIT_AR_C) && !areset;

  assign bvalid = (b_state == RSP_VALID);
  assign bresp  = bresp_q;
  assign rvalid = (r_state == RSP_VALID);
  assign rresp  = rresp_q;
  assign rdata  = rdata_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign b_hs  = bvalid  && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid  && rready;

  // Commit on the edge that captures the later of AW and W (or both together).
  assign commit = (aw_hs || w_hs)
               && (aw_hs || (aw_state == CAP_DONE))
               && (w_hs  || (w_state  == CAP_DONE));

  assign wr_addr = (aw_state == CAP_IDLE) ? awaddr : aw_addr_q;
  assign wr_data = (w_state  == CAP_IDLE) ? wdata  : w_data_q;
  assign wr_strb = (w_state  == CAP_IDLE) ? wstrb  : w_strb_q;

  // Offset wraps for addresses below the window, so one compare covers both bounds.
  assign wr_off = wr_addr - MIN_ADDRESS;
  assign rd_off = araddr - MIN_ADDRESS;
  assign wr_hit = (wr_off <= SPAN);
  assign rd_hit = (rd_off <= SPAN);
  assign wr_idx = wr_off[ADDR_LSB +: IDX_W];
  assign rd_idx = rd_off[ADDR_LSB +: IDX_W];
  assign wr_en  = commit && wr_hit;

  always_ff @(posedge aclk or posedge areset) begin : mem_write
    if (areset) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin : state_reg
    if (areset) begin
      aw_state  <= CAP_IDLE;
      aw_cnt    <= '0;
      aw_addr_q <= '0;
      w_state   <= CAP_IDLE;
      w_cnt     <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_state   <= RSP_IDLE;
      b_cnt     <= '0;
      bresp_q   <= '0;
      ar_state  <= CAP_IDLE;
      ar_cnt    <= '0;
      r_state   <= RSP_IDLE;
      r_cnt     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      aw_state  <= aw_state_nx;
      aw_cnt    <= aw_cnt_nx;
      aw_addr_q <= aw_addr_nx;
      w_state   <= w_state_nx;
      w_cnt     <= w_cnt_nx;
      w_data_q  <= w_data_nx;
      w_strb_q  <= w_strb_nx;
      b_state   <= b_state_nx;
      b_cnt     <= b_cnt_nx;
      bresp_q   <= bresp_nx;
      ar_state  <= ar_state_nx;
      ar_cnt    <= ar_cnt_nx;
      r_state   <= r_state_nx;
      r_cnt     <= r_cnt_nx;
      rdata_q   <= rdata_nx;
      rresp_q   <= rresp_nx;
    end
  end

  always_comb begin : next_state
    aw_state_nx = aw_state;
    aw_cnt_nx   = aw_cnt;
    aw_addr_nx  = aw_addr_q;
    w_state_nx  = w_state;
    w_cnt_nx    = w_cnt;
    w_data_nx   = w_data_q;
    w_strb_nx   = w_strb_q;
    b_state_nx  = b_state;
    b_cnt_nx    = b_cnt;
    bresp_nx    = bresp_q;
    ar_state_nx = ar_state;
    ar_cnt_nx   = ar_cnt;
    r_state_nx  = r_state;
    r_cnt_nx    = r_cnt;
    rdata_nx    = rdata_q;
    rresp_nx    = rresp_q;

    // AW capture: wait-state count runs only while valid is pending
    case (aw_state)
      CAP_IDLE: begin
        if (aw_hs) begin
          aw_state_nx = CAP_DONE;
          aw_cnt_nx   = '0;
          aw_addr_nx  = awaddr;
        end else if (awvalid) begin
          aw_cnt_nx = aw_cnt + CNT_W'(1);
        end
      end
      CAP_DONE: if (b_hs) aw_state_nx = CAP_IDLE;
      default:  aw_state_nx = CAP_IDLE;
    endcase

    case (w_state)
      CAP_IDLE: begin
        if (w_hs) begin
          w_state_nx = CAP_DONE;
          w_cnt_nx   = '0;
          w_data_nx  = wdata;
          w_strb_nx  = wstrb;
        end else if (wvalid) begin
          w_cnt_nx = w_cnt + CNT_W'(1);
        end
      end
      CAP_DONE: if (b_hs) w_state_nx = CAP_IDLE;
      default:  w_state_nx = CAP_IDLE;
    endcase

    // B response: counter k reaches WAIT_B on edge E+k
    case (b_state)
      RSP_IDLE: begin
        if (commit) begin
          bresp_nx   = wr_hit ? RESP_OKAY : RESP_DECERR;
          b_cnt_nx   = '0;
          b_state_nx = (WAIT_B_C == '0) ? RSP_VALID : RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        b_cnt_nx = b_cnt + CNT_W'(1);
        if ((b_cnt + CNT_W'(1)) == WAIT_B_C) b_state_nx = RSP_VALID;
      end
      RSP_VALID: if (bready) b_state_nx = RSP_IDLE;
      default:   b_state_nx = RSP_IDLE;
    endcase

    case (ar_state)
      CAP_IDLE: begin
        if (ar_hs) begin
          ar_state_nx = CAP_DONE;
          ar_cnt_nx   = '0;
        end else if (arvalid) begin
          ar_cnt_nx = ar_cnt + CNT_W'(1);
        end
      end
      CAP_DONE: if (r_hs) ar_state_nx = CAP_IDLE;
      default:  ar_state_nx = CAP_IDLE;
    endcase

    // Read data is taken from memory before any same-edge write lands
    case (r_state)
      RSP_IDLE: begin
        if (ar_hs) begin
          rdata_nx   = rd_hit ? mem[rd_idx] : '0;
          rresp_nx   = rd_hit ? RESP_OKAY : RESP_DECERR;
          r_cnt_nx   = '0;
          r_state_nx = (WAIT_R_C == '0) ? RSP_VALID : RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        r_cnt_nx = r_cnt + CNT_W'(1);
        if ((r_cnt + CNT_W'(1)) == WAIT_R_C) r_state_nx = RSP_VALID;
      end
      RSP_VALID: if (rready) r_state_nx = RSP_IDLE;
      default:   r_state_nx = RSP_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_slave_responder.sv
// Self-checking bench: scoreboarded write/read transactions against a default-timing instance and
// a wait-state instance, with a byte-lane memory model.
module tb_axi4_lite_slave_responder;

  logic        aclk;
  logic        areset;

  logic [31:0] awaddr;  logic [2:0] awprot;  logic awvalid;  logic awready;
  logic [31:0] wdata;   logic [3:0] wstrb;   logic wvalid;   logic wready;
  logic [1:0]  bresp;   logic bvalid;        logic bready;
  logic [31:0] araddr;  logic [2:0] arprot;  logic arvalid;  logic arready;
  logic [31:0] rdata;   logic [1:0] rresp;   logic rvalid;   logic rready;

  logic [31:0] x_awaddr;  logic [2:0] x_awprot;  logic x_awvalid;  logic x_awready;
  logic [31:0] x_wdata;   logic [3:0] x_wstrb;   logic x_wvalid;   logic x_wready;
  logic [1:0]  x_bresp;   logic x_bvalid;        logic x_bready;
  logic [31:0] x_araddr;  logic [2:0] x_arprot;  logic x_arvalid;  logic x_arready;
  logic [31:0] x_rdata;   logic [1:0] x_rresp;   logic x_rvalid;   logic x_rready;

  int checks;
  int errors;
  int last_lat;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [31:0] model [16];

  axi4_lite_slave_responder dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  axi4_lite_slave_responder #(.WAIT_AW(2), .WAIT_B(3), .WAIT_R(1)) dut_wait (
    .aclk(aclk), .areset(areset),
    .awaddr(x_awaddr), .awprot(x_awprot), .awvalid(x_awvalid), .awready(x_awready),
    .wdata(x_wdata), .wstrb(x_wstrb), .wvalid(x_wvalid), .wready(x_wready),
    .bresp(x_bresp), .bvalid(x_bvalid), .bready(x_bready),
    .araddr(x_araddr), .arprot(x_arprot), .arvalid(x_arvalid), .arready(x_arready),
    .rdata(x_rdata), .rresp(x_rresp), .rvalid(x_rvalid), .rready(x_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] e;
    logic a_s, w_s, a_done, w_done;
    int n;
    if (addr <= 32'h3F) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b11);
    end
    @(posedge aclk); #1;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    a_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(a_done && w_done) && n < 50) begin
      @(negedge aclk); a_s = awready; w_s = wready;
      @(posedge aclk); #1; n++;
      if (a_s && !a_done) begin a_done = 1'b1; awvalid = 1'b0; end
      if (w_s && !w_done) begin w_done = 1'b1; wvalid = 1'b0; end
    end
    while (!bvalid && n < 100) begin @(posedge aclk); #1; n++; end
    last_lat = n;
    e = bq.pop_front();
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL write_timeout addr=%h: bvalid=%b required 1", addr, bvalid);
    end else if (bresp !== e) begin
      errors++; $display("FAIL write_resp addr=%h: bresp=%b required %b", addr, bresp, e);
    end
    @(posedge aclk); #1; bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL write_release addr=%h: bvalid=%b required 0", addr, bvalid);
    end
  endtask

  task automatic do_read(input logic [31:0] addr);
    logic [33:0] e;
    logic a_s, done;
    int n;
    if (addr <= 32'h3F) rq.push_back({2'b00, model[addr[5:2]]});
    else                rq.push_back({2'b11, 32'h0});
    @(posedge aclk); #1;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 50) begin
      @(negedge aclk); a_s = arready;
      @(posedge aclk); #1; n++;
      if (a_s) begin done = 1'b1; arvalid = 1'b0; end
    end
    while (!rvalid && n < 100) begin @(posedge aclk); #1; n++; end
    last_lat = n;
    e = rq.pop_front();
    checks++;
    if (rvalid !== 1'b1) begin
      errors++; $display("FAIL read_timeout addr=%h: rvalid=%b required 1", addr, rvalid);
    end else if ({rresp, rdata} !== e) begin
      errors++;
      $display("FAIL read_data addr=%h: resp=%b data=%h required resp=%b data=%h",
               addr, rresp, rdata, e[33:32], e[31:0]);
    end
    @(posedge aclk); #1; rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL read_release addr=%h: rvalid=%b required 0", addr, rvalid);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs: aw/w/ar ready=%b%b%b bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h required all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
    end
    checks++;
    if ({x_awready, x_wready, x_arready, x_bvalid, x_rvalid, x_bresp, x_rresp, x_rdata} !== 41'd0) begin
      errors++; $display("FAIL reset_outputs_wait: some output nonzero, rdata=%h", x_rdata);
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk); areset = 1'b0;
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      errors++; $display("FAIL reset_release: aw/w/ar ready,bvalid,rvalid=%b required 11100",
                         {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({x_awready, x_wready, x_arready} !== 3'b011) begin
      errors++; $display("FAIL reset_release_wait: aw/w/ar ready=%b required 011",
                         {x_awready, x_wready, x_arready});
    end
  endtask

  task automatic test_strobed();
    do_write(32'h4, 32'hDEADBEEF, 4'hF);
    checks++;
    if (last_lat != 1) begin errors++; $display("FAIL write_latency: %0d edges required 1", last_lat); end
    do_read(32'h4);
    checks++;
    if (last_lat != 1) begin errors++; $display("FAIL read_latency: %0d edges required 1", last_lat); end
    do_write(32'h4, 32'h0000AA00, 4'b0010);
    do_read(32'h4);
    checks++;
    if (model[1] !== 32'hDEADAAEF) begin
      errors++; $display("FAIL model_merge: %h required DEADAAEF", model[1]);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] e;
    logic seen_b;
    model[2] = 32'h12345678;
    bq.push_back(2'b00);
    seen_b = 1'b0;
    @(posedge aclk); #1;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; awaddr = 32'h8; bready = 1'b0;
    repeat (3) begin
      @(posedge aclk); #1;
      if (bvalid) seen_b = 1'b1;
    end
    checks++;
    if (seen_b !== 1'b0) begin errors++; $display("FAIL w_first_bvalid: bvalid=1 before AW required 0"); end
    checks++;
    if (wready !== 1'b0) begin errors++; $display("FAIL w_first_captured: wready=%b required 0", wready); end
    wvalid = 1'b0; awvalid = 1'b1;
    @(posedge aclk); #1; awvalid = 1'b0;
    e = bq.pop_front();
    checks++;
    if (bvalid !== 1'b1 || bresp !== e) begin
      errors++; $display("FAIL w_first_resp: bvalid=%b bresp=%b required 1 %b", bvalid, bresp, e);
    end
    bready = 1'b1;
    @(posedge aclk); #1; bready = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++; $display("FAIL w_first_release: bvalid,awready,wready=%b required 011",
                         {bvalid, awready, wready});
    end
    do_read(32'h8);
  endtask

  task automatic test_wstrb_zero();
    do_write(32'h4, 32'hFFFFFFFF, 4'h0);
    do_read(32'h4);
  endtask

  task automatic test_decerr();
    do_write(32'h43, 32'hA5A5A5A5, 4'hF);
    do_read(32'h43);
    do_read(32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      do_write(a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++) do_read(32'(i) << 2);
  endtask

  task automatic test_same_edge();
    logic [1:0]  eb;
    logic [33:0] er;
    do_write(32'h10, 32'h11112222, 4'hF);
    bq.push_back(2'b00);
    rq.push_back({2'b00, model[4]});
    model[4] = 32'h55AA55AA;
    @(posedge aclk); #1;
    awaddr = 32'h10; wdata = 32'h55AA55AA; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    eb = bq.pop_front();
    er = rq.pop_front();
    checks++;
    if (bvalid !== 1'b1 || bresp !== eb) begin
      errors++; $display("FAIL same_edge_b: bvalid=%b bresp=%b required 1 %b", bvalid, bresp, eb);
    end
    checks++;
    if (rvalid !== 1'b1 || {rresp, rdata} !== er) begin
      errors++; $display("FAIL same_edge_r: rvalid=%b rresp=%b rdata=%h required 1 %b %h",
                         rvalid, rresp, rdata, er[33:32], er[31:0]);
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1; bready = 1'b0; rready = 1'b0;
    do_read(32'h10);
  endtask

  task automatic test_wait_states();
    logic [1:0] e;
    int n;
    int m;
    bq.push_back(2'b00);
    @(posedge aclk); #1;
    x_awaddr = 32'h20; x_wdata = 32'hCAFEF00D; x_wstrb = 4'hF;
    x_awvalid = 1'b1; x_wvalid = 1'b1; x_bready = 1'b0;
    n = 0;
    do begin
      @(posedge aclk); #1; n++;
      if (n == 1) begin
        x_wvalid = 1'b0;
        checks++;
        if (x_wready !== 1'b0) begin errors++; $display("FAIL wait_w_captured: wready=%b required 0", x_wready); end
      end
    end while (!x_awready && n < 20);
    checks++;
    if (n != 2) begin errors++; $display("FAIL wait_awready: rose after %0d edges required 2", n); end
    @(posedge aclk); #1; x_awvalid = 1'b0;
    m = 0;
    while (!x_bvalid && m < 20) begin @(posedge aclk); #1; m++; end
    checks++;
    if (m != 3) begin errors++; $display("FAIL wait_bvalid: rose %0d edges after commit required 3", m); end
    e = bq.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      checks++;
      if (x_bvalid !== 1'b1 || x_bresp !== e) begin
        errors++; $display("FAIL wait_b_stable cycle %0d: bvalid=%b bresp=%b required 1 %b", i, x_bvalid, x_bresp, e);
      end
    end
    x_bready = 1'b1;
    @(posedge aclk); #1; x_bready = 1'b0;
    checks++;
    if ({x_bvalid, x_awready, x_wready} !== 3'b001) begin
      errors++; $display("FAIL wait_b_release: bvalid,awready,wready=%b required 001",
                         {x_bvalid, x_awready, x_wready});
    end
    rq.push_back({2'b00, 32'hCAFEF00D});
    @(posedge aclk); #1; x_araddr = 32'h20; x_arvalid = 1'b1; x_rready = 1'b0;
    @(posedge aclk); #1; x_arvalid = 1'b0;
    checks++;
    if ({x_rvalid, x_arready} !== 2'b00) begin
      errors++; $display("FAIL wait_r_early: rvalid,arready=%b required 00", {x_rvalid, x_arready});
    end
    @(posedge aclk); #1;
    checks++;
    if (x_rvalid !== 1'b1 || {x_rresp, x_rdata} !== rq[0]) begin
      errors++; $display("FAIL wait_r_data: rvalid=%b rresp=%b rdata=%h required 1 00 cafef00d",
                         x_rvalid, x_rresp, x_rdata);
    end
    void'(rq.pop_front());
    x_rready = 1'b1;
    @(posedge aclk); #1; x_rready = 1'b0;
    checks++;
    if (x_rvalid !== 1'b0) begin errors++; $display("FAIL wait_r_release: rvalid=%b required 0", x_rvalid); end
  endtask

  task automatic test_reset_mid();
    @(posedge aclk); #1; araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
    @(posedge aclk); #1; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid: rvalid=%b required 1", rvalid); end
    #2; areset = 1'b1;
    #1;
    checks++;
    if ({rvalid, rdata, rresp, arready, awready, wready} !== 38'd0) begin
      errors++; $display("FAIL mid_reset_async: rvalid=%b rdata=%h arready=%b required 0 0 0",
                         rvalid, rdata, arready);
    end
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    repeat (2) @(posedge aclk);
    @(negedge aclk); areset = 1'b0;
    do_read(32'h4);
    do_read(32'h8);
  endtask

  initial begin
    checks = 0; errors = 0; last_lat = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    areset = 1'b1;
    awaddr = '0; awprot = 3'b010; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b001; arvalid = 1'b0; rready = 1'b0;
    x_awaddr = '0; x_awprot = '0; x_awvalid = 1'b0; x_wdata = '0; x_wstrb = '0; x_wvalid = 1'b0; x_bready = 1'b0;
    x_araddr = '0; x_arprot = '0; x_arvalid = 1'b0; x_rready = 1'b0;

    test_reset();
    test_strobed();
    test_w_before_aw();
    test_wstrb_zero();
    test_decerr();
    test_back_to_back();
    test_same_edge();
    test_wait_states();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
